icache: RTL

Direct-mapped instruction cache between the instruction fetcher and the memory controller's instruction port. It serves a hit one cycle after the fetch request is accepted. On a miss it holds a word request to the memory controller until the fetched word returns, writes the line, and forwards the word. It is one word per line and read-only; stores to code space are not snooped.

---
 rtl/icache.sv | 79 +++++++
 1 files changed

// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-line read-only instruction cache
// between the fetcher and the memory controller's instruction port.
module icache #(
    parameter int IDX_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clr,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_addr,
    output logic        fetch_ready,
    output logic        ins_rdy,
    output logic [31:0] ins,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_ins
);
    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {IDLE, MISS} state_t;

    state_t state, state_nx;
    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags [LINES];
    logic [31:0] data [LINES];
    logic [IDX_W-1:0] idx, miss_idx;
    logic [TAG_W-1:0] tag, miss_tag;
    logic hit, accept, fill, unused;

    assign idx = fetch_addr[IDX_W+1:2];
    assign tag = fetch_addr[31:IDX_W+2];
    // mem_addr holds the miss address for the whole miss, so it doubles as the miss latch
    assign miss_idx = mem_addr[IDX_W+1:2];
    assign miss_tag = mem_addr[31:IDX_W+2];
    assign unused = ^fetch_addr[1:0];
    assign hit = valid[idx] && tags[idx] == tag;
    assign fetch_ready = state == IDLE && !clr;
    assign accept = rdy && fetch_valid && fetch_ready;
    assign fill = rdy && state == MISS && mem_done;

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        if (accept && !hit) state_nx = MISS;
        if (rdy && state == MISS && (clr || mem_done)) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            valid <= '0;
            ins_rdy <= 1'b0;
            ins <= '0;
            mem_req <= 1'b0;
            mem_addr <= '0;
        end else if (rdy) begin
            ins_rdy <= !clr && ((accept && hit) || fill);
            if (accept && hit) ins <= data[idx];
            if (fill && !clr) ins <= mem_ins;
            if (fill) valid[miss_idx] <= 1'b1;
            if (accept && !hit) begin
                mem_req <= 1'b1;
                mem_addr <= {fetch_addr[31:2], 2'b00};
            end
            if (state == MISS && (clr || mem_done)) mem_req <= 1'b0;
        end

    // a fill coincident with clr is still written: the returned word is valid
    always_ff @(posedge clk)
        if (rst && fill) begin
            tags[miss_idx] <= miss_tag;
            data[miss_idx] <= mem_ins;
        end
endmodule
